// File: rtl/simon_defs.sv
// simon_defs: shared state encoding and LED patterns for the Simon round controller
package simon_defs;
  typedef enum logic [2:0] {IDLE, APPEND, SHOW_ON, SHOW_GAP, WAIT_IN, WIN, LOSE} state_t;
  localparam logic [7:0] WIN_PATTERN = 8'hFF;
  localparam logic [7:0] LOSE_PATTERN = 8'h81;
endpackage

// File: rtl/simon_seq_mem.sv
// simon_seq_mem: DEPTH x 8 sequence store; ports clock, we/waddr/wdata (sync write), raddr/rdata (comb read)
module simon_seq_mem #(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clock)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/simon_round_ctrl.sv
// simon_round_ctrl: Simon game loop; in clock/reset/start/random_num/swt/enter_move, out led_out/level/busy/win/lose
module simon_round_ctrl
  import simon_defs::*;
#(
  parameter int MAX_LEN = 16,
  parameter int SHOW_CYCLES = 25000000,
  parameter int GAP_CYCLES = 12500000,
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    random_num,
  input  logic [7:0]    swt,
  input  logic          enter_move,
  output logic [7:0]    led_out,
  output logic [LW-1:0] level,
  output logic          busy,
  output logic          win,
  output logic          lose
);
  localparam int IW = $clog2(MAX_LEN);
  localparam int TW = $clog2((SHOW_CYCLES > GAP_CYCLES ? SHOW_CYCLES : GAP_CYCLES) + 1);
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n, raddr;
  logic [LW-1:0] level_n;
  logic [TW-1:0] timer, timer_n;
  logic [7:0] rdata, show_data, led_n;
  logic last, match, show_done, gap_done;
  // read address only ever needs the element about to be shown or the one being checked,
  // so it is derived from the current state alone to keep the compare path loop-free
  assign raddr = state == WAIT_IN ? idx : state == SHOW_GAP ? idx + IW'(1) : '0;
  // first round writes seq[0] on the same edge that starts playback: forward the sample
  assign show_data = (state == APPEND && level == '0) ? random_num : rdata;
  assign last = LW'(idx) == level - LW'(1);
  assign match = swt == rdata;
  assign show_done = timer == TW'(SHOW_CYCLES - 1);
  assign gap_done = timer == TW'(GAP_CYCLES - 1);
  simon_seq_mem #(.DEPTH(MAX_LEN), .AW(IW)) u_mem (
    .clock(clock),
    .we(state == APPEND),
    .waddr(IW'(level)),
    .wdata(random_num),
    .raddr(raddr),
    .rdata(rdata)
  );
  always_comb begin
    state_n = state;
    idx_n = idx;
    level_n = level;
    timer_n = timer;
    case (state)
      IDLE, WIN, LOSE: if (start) begin
        level_n = '0;
        state_n = APPEND;
      end
      APPEND: begin
        level_n = level + LW'(1);
        idx_n = '0;
        timer_n = '0;
        state_n = SHOW_ON;
      end
      SHOW_ON: if (show_done) begin
        timer_n = '0;
        state_n = SHOW_GAP;
      end else timer_n = timer + TW'(1);
      SHOW_GAP: if (gap_done) begin
        timer_n = '0;
        idx_n = last ? '0 : idx + IW'(1);
        state_n = last ? WAIT_IN : SHOW_ON;
      end else timer_n = timer + TW'(1);
      WAIT_IN: if (enter_move) begin
        if (!match) state_n = LOSE;
        else if (!last) idx_n = idx + IW'(1);
        else state_n = level == LW'(MAX_LEN) ? WIN : APPEND;
      end
      default: state_n = IDLE;
    endcase
    led_n = state_n == SHOW_ON ? (state == SHOW_ON ? led_out : show_data) :
            state_n == WAIT_IN ? swt :
            state_n == WIN ? WIN_PATTERN :
            state_n == LOSE ? LOSE_PATTERN : '0;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      level <= '0;
      timer <= '0;
      led_out <= '0;
      busy <= 1'b0;
      win <= 1'b0;
      lose <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      level <= level_n;
      timer <= timer_n;
      led_out <= led_n;
      busy <= !(state_n inside {IDLE, WIN, LOSE});
      win <= state_n == WIN && state != WIN;
      lose <= state_n == LOSE && state != LOSE;
    end
endmodule

// File: tb/tb_simon_round_ctrl.sv
// tb_simon_round_ctrl: randomized game-level checks of simon_round_ctrl against a sequence model
module tb_simon_round_ctrl;
  localparam int MAX_LEN = 4;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic enter_move = 1'b0;
  logic [7:0] random_num = 8'h00;
  logic [7:0] swt = 8'h00;
  logic [7:0] led_out;
  logic [2:0] level;
  logic busy, win, lose;
  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] rnd_tab [MAX_LEN];
  always #5 clock = ~clock;
  simon_round_ctrl #(.MAX_LEN(MAX_LEN), .SHOW_CYCLES(3), .GAP_CYCLES(2)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .random_num(random_num),
    .swt(swt),
    .enter_move(enter_move),
    .led_out(led_out),
    .level(level),
    .busy(busy),
    .win(win),
    .lose(lose)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic expect_out(input string tag, input logic [7:0] led, input int lvl, input logic bsy);
    check({tag, "_led"}, 32'(led_out), 32'(led));
    check({tag, "_level"}, 32'(level), 32'(lvl));
    check({tag, "_busy"}, 32'(busy), 32'(bsy));
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic noise();
    enter_move = 1'($urandom_range(0, 1));
    start = 1'($urandom_range(0, 1));
    swt = 8'($urandom);
  endtask
  task automatic quiet();
    enter_move = 1'b0;
    start = 1'b0;
  endtask
  // err_r < 0: play perfectly to a win; otherwise enter a wrong value (seq ^ flip) at move err_m of round err_r
  task automatic play_game(input int err_r, input int err_m, input logic [7:0] flip);
    logic [7:0] model [$];
    logic [7:0] v;
    logic bad;
    model = {};
    start = 1'b1;
    random_num = rnd_tab[0];
    tick();
    start = 1'b0;
    for (int r = 0; r < MAX_LEN; r++) begin
      check("append_busy", 32'(busy), 32'd1);
      check("append_level", 32'(level), 32'(model.size()));
      model.push_back(rnd_tab[r]);
      tick();
      random_num = 8'($urandom);
      for (int i = 0; i < model.size(); i++)
        for (int c = 0; c < 5; c++) begin
          expect_out("play", c < 3 ? model[i] : 8'h00, model.size(), 1'b1);
          noise();
          tick();
          quiet();
        end
      swt = 8'($urandom);
      start = 1'($urandom_range(0, 1));
      tick();
      start = 1'b0;
      expect_out("wait", swt, model.size(), 1'b1);
      for (int m = 0; m < model.size(); m++) begin
        bad = r == err_r && m == err_m;
        v = bad ? model[m] ^ flip : model[m];
        swt = v;
        enter_move = 1'b1;
        start = 1'($urandom_range(0, 1));
        tick();
        quiet();
        if (bad) begin
          check("lose_pulse", 32'(lose), 32'd1);
          expect_out("lose", 8'h81, model.size(), 1'b0);
          tick();
          check("lose_after", 32'(lose), 32'd0);
          check("lose_win", 32'(win), 32'd0);
          expect_out("lose_hold", 8'h81, model.size(), 1'b0);
          return;
        end else if (m < model.size() - 1) begin
          expect_out("move_ok", v, model.size(), 1'b1);
        end else if (model.size() == MAX_LEN) begin
          check("win_pulse", 32'(win), 32'd1);
          expect_out("win", 8'hFF, MAX_LEN, 1'b0);
          tick();
          check("win_after", 32'(win), 32'd0);
          tick();
          check("win_lose", 32'(lose), 32'd0);
          expect_out("win_hold", 8'hFF, MAX_LEN, 1'b0);
          return;
        end else begin
          random_num = rnd_tab[r + 1];
        end
      end
    end
  endtask
  initial begin
    int er, em;
    #1 reset = 1'b1;
    #10;
    expect_out("reset", 8'h00, 0, 1'b0);
    check("reset_win", 32'(win), 32'd0);
    check("reset_lose", 32'(lose), 32'd0);
    reset = 1'b0;
    rnd_tab = '{8'h05, 8'h3C, 8'h80, 8'hFF};
    play_game(-1, 0, 8'h01);
    play_game(1, 1, 8'h01);
    rnd_tab = '{8'h11, 8'h22, 8'h33, 8'h44};
    play_game(2, 1, 8'h40);
    start = 1'b1;
    random_num = 8'h42;
    tick();
    start = 1'b0;
    tick();
    expect_out("pre_reset", 8'h42, 1, 1'b1);
    #2 reset = 1'b1;
    #1 expect_out("async_reset", 8'h00, 0, 1'b0);
    #1 reset = 1'b0;
    rnd_tab = '{8'h00, 8'h99, 8'h00, 8'h5A};
    play_game(-1, 0, 8'h01);
    for (int g = 0; g < 20; g++) begin
      for (int k = 0; k < MAX_LEN; k++) rnd_tab[k] = 8'($urandom);
      er = int'($urandom_range(0, MAX_LEN));
      if (er == MAX_LEN) er = -1;
      em = er < 0 ? 0 : int'($urandom_range(0, er));
      play_game(er, em, 8'($urandom_range(1, 255)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
